// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flow control for the 5-stage pipeline: enables and valid_ins are combinational (0 cycles); counters and ctrl_state lag one cycle.
// Backpressure: dmem_busy freezes every stage; a taken branch squashes the 3 younger slots; load-use or flag hazards insert one bubble.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_reads_flags,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_flag_write,
  input  logic             mem_branch_taken,
  input  logic             dmem_busy,
  input  logic             clear_counts,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_valid_in,
  output logic             id_ex_enable,
  output logic             id_ex_valid_in,
  output logic             ex_mem_enable,
  output logic             ex_mem_valid_in,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_FREEZE = 2'd3
  } action_e;

  action_e         action_d;
  action_e         ctrl_state_q;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] flush_count_q;
  logic            match_rn;
  logic            match_rm;
  logic            load_use;
  logic            flag_haz;

  // XZR as a load destination never creates a dependency.
  assign match_rn = id_uses_rn & (id_rn == ex_rd);
  assign match_rm = id_uses_rm & (id_rm == ex_rd);
  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd31) & (match_rn | match_rm);
  assign flag_haz = id_valid & ex_valid & ex_flag_write & id_reads_flags;

  always_comb begin
    action_d = ACT_RUN;
    if (dmem_busy)                  action_d = ACT_FREEZE;
    else if (mem_branch_taken)      action_d = ACT_FLUSH;
    else if (load_use || flag_haz)  action_d = ACT_STALL;
  end

  always_comb begin
    pc_enable       = 1'b1;
    if_id_enable    = 1'b1;
    id_ex_enable    = 1'b1;
    ex_mem_enable   = 1'b1;
    if_id_valid_in  = 1'b0;
    id_ex_valid_in  = 1'b0;
    ex_mem_valid_in = 1'b0;
    if (!reset) begin
      unique case (action_d)
        ACT_RUN: begin
          if_id_valid_in  = 1'b1;
          id_ex_valid_in  = id_valid;
          ex_mem_valid_in = 1'b1;
        end
        ACT_STALL: begin
          pc_enable       = 1'b0;
          if_id_enable    = 1'b0;
          if_id_valid_in  = 1'b1;
          ex_mem_valid_in = 1'b1;
        end
        ACT_FLUSH: ;
        ACT_FREEZE: begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_state_q  <= ACT_RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ctrl_state_q <= action_d;
      // Clear beats increment; both counters stick at all-ones.
      if (clear_counts)
        stall_count_q <= '0;
      else if (action_d == ACT_STALL && stall_count_q != '1)
        stall_count_q <= stall_count_q + 1'b1;
      if (clear_counts)
        flush_count_q <= '0;
      else if (action_d == ACT_FLUSH && flush_count_q != '1)
        flush_count_q <= flush_count_q + 1'b1;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
  assign ctrl_state  = ctrl_state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and flow-control unit for the 5-stage pipeline. Each cycle it decides whether the ID/EX pipeline register, and the registers around it, load new contents, hold them, or take a bubble. It drives the `enable` and `valid_in` inputs of the IF/ID, ID/EX and EX/MEM registers from the decode fields of the instruction in ID and from the ID/EX outputs. It also keeps saturating stall and flush event counters and a registered copy of the last action, for debug.

## Interface
Parameters:
- CNT_W, 32, width of each event counter

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  instruction in ID is valid
- id_rn  in  5  first source register of the ID instruction
- id_rm  in  5  second source register of the ID instruction
- id_uses_rn  in  1  ID instruction reads id_rn
- id_uses_rm  in  1  ID instruction reads id_rm
- id_reads_flags  in  1  ID instruction is B.LT (consumes flags)
- ex_valid  in  1  ID/EX valid_out
- ex_rd  in  5  ID/EX rd_out
- ex_mem_read  in  1  ID/EX mem_mem_read_out (load in EX)
- ex_flag_write  in  1  ID/EX ex_flag_write_out
- mem_branch_taken  in  1  branch resolved taken in MEM (already qualified by MEM valid)
- dmem_busy  in  1  data memory not ready; whole pipeline must freeze
- clear_counts  in  1  synchronous clear of both counters
- pc_enable  out  1  PC register enable
- if_id_enable  out  1  IF/ID enable
- if_id_valid_in  out  1  IF/ID valid_in
- id_ex_enable  out  1  ID/EX enable
- id_ex_valid_in  out  1  ID/EX valid_in
- ex_mem_enable  out  1  EX/MEM enable
- ex_mem_valid_in  out  1  EX/MEM valid_in; ANDed with ex_valid by the integrator
- stall_count  out  CNT_W  number of load-use or flag stall cycles
- flush_count  out  CNT_W  number of taken-branch flush events
- ctrl_state  out  2  action taken in the previous cycle: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE

## Operation
- Hazard terms, evaluated combinationally each cycle:
  - match_rn = id_uses_rn & (id_rn == ex_rd)
  - match_rm = id_uses_rm & (id_rm == ex_rd)
  - load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != 31) & (match_rn | match_rm)
  - flag_haz = id_valid & ex_valid & ex_flag_write & id_reads_flags
  - X31 (XZR) never creates a dependency.
- Action priority, one action per cycle: FREEZE (dmem_busy) > FLUSH (mem_branch_taken) > STALL (load_use | flag_haz) > RUN.
- RUN:
  - all enables = 1
  - if_id_valid_in = 1, id_ex_valid_in = id_valid, ex_mem_valid_in = 1
- STALL:
  - pc_enable = if_id_enable = 0; id_ex_enable = ex_mem_enable = 1
  - id_ex_valid_in = 0 (bubble); if_id_valid_in = 1; ex_mem_valid_in = 1
- FLUSH:
  - all enables = 1
  - if_id_valid_in = id_ex_valid_in = ex_mem_valid_in = 0, squashing the 3 younger instructions
  - PC redirect is handled by the fetch mux; pc_enable = 1
- FREEZE:
  - all enables = 0; valid_in outputs = 0 (don't-care while enables are low)
  - a pending branch or hazard is re-evaluated once dmem_busy drops
- Counters, updated on the clock edge:
  - stall_count += 1 on each STALL cycle; flush_count += 1 on each FLUSH cycle
  - both saturate at 2^CNT_W-1, no wrap
  - clear_counts wins over an increment in the same cycle; the counter becomes 0
- ctrl_state <= action code on every edge, including FREEZE.

## Timing
- Enable and valid outputs are purely combinational from current inputs, with zero-cycle latency. They must settle within the same cycle, before the pipeline-register edge.
- Counters and ctrl_state have 1-cycle latency; they show the action of the previous cycle.
- A load-use stall lasts exactly 1 cycle: after the bubble the load leaves EX, so ex_mem_read no longer matches. flag_haz behaves the same way.
- While reset is high:
  - pc_enable = if_id_enable = id_ex_enable = ex_mem_enable = 1
  - all valid_in outputs = 0
  - stall_count = flush_count = 0; ctrl_state = 0
- Reset is asynchronous; deassertion takes effect at the next edge. Reset mid-stall or mid-freeze returns ctrl_state to RUN immediately.
- Simultaneous mem_branch_taken and load_use: FLUSH wins; stall_count is not incremented.

## Test plan
- Reset: reset=1 mid-run → enables all 1, valid_in all 0, counters 0, ctrl_state 0 immediately.
- Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5, id_rn=5, id_uses_rn=1 → pc_enable=0, if_id_enable=0, id_ex_valid_in=0 for one cycle; stall_count 0→1, ctrl_state=1 next cycle. Repeat with ex_rd=31 → RUN, no stall.
- Flag hazard: ex_flag_write=1, id_reads_flags=1 → one STALL cycle. Same with ex_valid=0 → RUN.
- Branch flush with concurrent hazard: mem_branch_taken=1 together with load_use=1 → if_id/id_ex/ex_mem valid_in all 0, enables all 1; flush_count +1, stall_count unchanged, ctrl_state=2.
- Freeze: dmem_busy=1 for 3 cycles with mem_branch_taken=1 → all enables 0 for 3 cycles and no count changes; FLUSH occurs on the first cycle after dmem_busy=0.
- Counter saturation and clear: CNT_W=4, 20 consecutive stall cycles → stall_count holds 15. clear_counts=1 together with a stall → stall_count=0.
